// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: round-robin frame arbiter in front of one myFFT core.
// Two requesters compete for whole NFFT-sample frames. The winner streams one
// contiguous valid burst into the core. Each granted frame is tagged with its
// requester ID in a small FIFO, and the tag at the FIFO head labels the core's
// output burst.
// Optional feature macro: FFT_SCHED_FRAME_CNT_EN adds per-tag frame counters
// (stat_frames0/stat_frames1).
module fft_frame_scheduler #(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16,
    parameter int DATA_OUT_SIZE = 22,
    parameter int TAG_DEPTH_LOG = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s0_req,
    input  logic                     s1_req,
    input  logic [DATA_FFT_SIZE-1:0] s0_data_i,
    input  logic [DATA_FFT_SIZE-1:0] s0_data_q,
    input  logic [DATA_FFT_SIZE-1:0] s1_data_i,
    input  logic [DATA_FFT_SIZE-1:0] s1_data_q,
    output logic                     s0_ready,
    output logic                     s1_ready,
    output logic                     fft_valid,
    output logic [DATA_FFT_SIZE-1:0] fft_data_i,
    output logic [DATA_FFT_SIZE-1:0] fft_data_q,
    input  logic                     fft_wayt_data,
    input  logic                     fft_complete,
    input  logic [DATA_OUT_SIZE-1:0] fft_out_i,
    input  logic [DATA_OUT_SIZE-1:0] fft_out_q,
    output logic                     fft_ready_recive,
    output logic                     m_valid,
    output logic                     m_last,
    output logic                     m_tag,
    output logic [DATA_OUT_SIZE-1:0] m_data_i,
    output logic [DATA_OUT_SIZE-1:0] m_data_q,
    input  logic                     m_ready,
    output logic                     err_orphan
`ifdef FFT_SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]              stat_frames0,
    output logic [15:0]              stat_frames1
`endif
);

    localparam int NFFT  = 1 << SIZE_BUFFER;
    localparam int DEPTH = 1 << TAG_DEPTH_LOG;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                   state, state_nxt;
    logic                     sel, last_grant, winner, grant;
    logic [SIZE_BUFFER-1:0]   in_cnt, out_cnt;
    logic [DEPTH-1:0]         tag_mem;
    logic [TAG_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [TAG_DEPTH_LOG:0]   count;
    logic                     fifo_full, fifo_empty, pop, out_hs;

    assign fifo_full  = (count == (TAG_DEPTH_LOG+1)'(DEPTH));
    assign fifo_empty = (count == '0);

    // Round-robin pick: on a tie the requester not granted last time wins.
    always_comb begin
        if (s0_req && s1_req) winner = ~last_grant;
        else                  winner = s1_req;
    end

    // Input FSM next state and burst-side outputs.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        fft_valid  = 1'b0;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        fft_data_i = '0;
        fft_data_q = '0;
        case (state)
            IDLE: begin
                if (fft_wayt_data && !fifo_full && (s0_req || s1_req)) begin
                    grant     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                fft_valid  = 1'b1;
                s0_ready   = ~sel;
                s1_ready   = sel;
                fft_data_i = sel ? s1_data_i : s0_data_i;
                fft_data_q = sel ? s1_data_q : s0_data_q;
                if (in_cnt == SIZE_BUFFER'(NFFT-1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, grant bookkeeping and in-frame sample counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            in_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sel        <= winner;
                last_grant <= winner;
                in_cnt     <= '0;
            end else if (state == LOAD) begin
                in_cnt <= in_cnt + 1'b1;
            end
        end
    end

    // Output path is pure pass-through; only valid/last/tag come from here.
    assign m_valid          = fft_complete & ~fifo_empty;
    assign m_last           = m_valid & (out_cnt == SIZE_BUFFER'(NFFT-1));
    assign m_tag            = tag_mem[rd_ptr];
    assign m_data_i         = fft_out_i;
    assign m_data_q         = fft_out_q;
    assign fft_ready_recive = m_ready;
    assign out_hs           = m_valid & m_ready;
    assign pop              = m_last & m_ready;

    // Output sample counter, restarted at each frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      out_cnt <= '0;
        else if (pop)    out_cnt <= '0;
        else if (out_hs) out_cnt <= out_cnt + 1'b1;
    end

    // Tag FIFO: push on grant, pop on the last-sample handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (grant) begin
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag: core produced output with no frame tag outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          err_orphan <= 1'b0;
        else if (fft_complete && fifo_empty) err_orphan <= 1'b1;
    end

`ifdef FFT_SCHED_FRAME_CNT_EN
    // Per-tag completed-frame counters, free-running wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_frames0 <= '0;
            stat_frames1 <= '0;
        end else if (pop) begin
            if (m_tag) stat_frames1 <= stat_frames1 + 16'd1;
            else       stat_frames0 <= stat_frames0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: table of grant/drain records plus
// hand-written sequences for orphan, FIFO-full and mid-burst reset cases.
module tb_fft_frame_scheduler;

    localparam int DW   = 16;
    localparam int OW   = 22;
    localparam int NFFT = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          s0_req, s1_req;
    logic [DW-1:0] s0_data_i, s0_data_q, s1_data_i, s1_data_q;
    logic          s0_ready, s1_ready, fft_valid;
    logic [DW-1:0] fft_data_i, fft_data_q;
    logic          fft_wayt_data, fft_complete;
    logic [OW-1:0] fft_out_i, fft_out_q;
    logic          fft_ready_recive, m_valid, m_last, m_tag;
    logic [OW-1:0] m_data_i, m_data_q;
    logic          m_ready, err_orphan;
`ifdef FFT_SCHED_FRAME_CNT_EN
    logic [15:0]   stat_frames0, stat_frames1;
`endif

    int checks   = 0;
    int failures = 0;

    fft_frame_scheduler dut (
        .clk(clk), .reset(reset),
        .s0_req(s0_req), .s1_req(s1_req),
        .s0_data_i(s0_data_i), .s0_data_q(s0_data_q),
        .s1_data_i(s1_data_i), .s1_data_q(s1_data_q),
        .s0_ready(s0_ready), .s1_ready(s1_ready),
        .fft_valid(fft_valid), .fft_data_i(fft_data_i), .fft_data_q(fft_data_q),
        .fft_wayt_data(fft_wayt_data), .fft_complete(fft_complete),
        .fft_out_i(fft_out_i), .fft_out_q(fft_out_q),
        .fft_ready_recive(fft_ready_recive),
        .m_valid(m_valid), .m_last(m_last), .m_tag(m_tag),
        .m_data_i(m_data_i), .m_data_q(m_data_q),
        .m_ready(m_ready), .err_orphan(err_orphan)
`ifdef FFT_SCHED_FRAME_CNT_EN
        , .stat_frames0(stat_frames0), .stat_frames1(stat_frames1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_samples();
        s0_data_i = DW'($urandom);
        s0_data_q = DW'($urandom);
        s1_data_i = DW'($urandom);
        s1_data_q = DW'($urandom);
    endtask

    // Waits for a burst, then measures it. gap counts non-ready cycles seen
    // before the burst (starting with the current one).
    task automatic burst(input bit drop, output int who, output int gap,
                         output int len, output bit dok);
        gap = 0; len = 0; dok = 1'b1; who = -1;
        drive_samples(); #1;
        while (!(s0_ready || s1_ready) && gap < 2000) begin
            gap++; step(); drive_samples(); #1;
        end
        if (!(s0_ready || s1_ready)) return;
        who = s1_ready ? 1 : 0;
        if (drop) begin s0_req = 1'b0; s1_req = 1'b0; end
        while ((who == 1 ? s1_ready : s0_ready) && len < 400) begin
            len++;
            if (fft_valid !== 1'b1) dok = 1'b0;
            if (who == 1 && (s0_ready !== 1'b0 || fft_data_i !== s1_data_i || fft_data_q !== s1_data_q)) dok = 1'b0;
            if (who == 0 && (s1_ready !== 1'b0 || fft_data_i !== s0_data_i || fft_data_q !== s0_data_q)) dok = 1'b0;
            step(); drive_samples(); #1;
        end
    endtask

    // Feeds one core output frame and checks the tagged output stream.
    task automatic drain(input bit tog, input bit exp_tag, input string nm);
        int acc = 0;
        int cyc = 0;
        bit ok_v = 1, ok_t = 1, ok_l = 1, ok_r = 1, ok_d = 1;
        fft_complete = 1'b1;
        while (acc < NFFT && cyc < 2000) begin
            m_ready   = tog ? (cyc % 2 == 0) : 1'b1;
            fft_out_i = OW'($urandom);
            fft_out_q = OW'($urandom);
            #1;
            if (m_valid !== 1'b1) ok_v = 0;
            if (m_tag !== exp_tag) ok_t = 0;
            if (m_last !== (acc == NFFT-1)) ok_l = 0;
            if (fft_ready_recive !== m_ready) ok_r = 0;
            if (m_data_i !== fft_out_i || m_data_q !== fft_out_q) ok_d = 0;
            if (m_ready) acc++;
            cyc++;
            step();
        end
        fft_complete = 1'b0;
        m_ready      = 1'b0;
        chk({nm, " accepted"}, acc, NFFT);
        chk({nm, " m_valid"}, ok_v, 1);
        chk({nm, " m_tag"}, ok_t, 1);
        chk({nm, " m_last position"}, ok_l, 1);
        chk({nm, " ready_recive"}, ok_r, 1);
        chk({nm, " m_data"}, ok_d, 1);
    endtask

    task automatic reset_pulse();
        reset = 1'b0; #1;
        step();
        reset = 1'b1;
    endtask

    typedef struct {
        bit r0;
        bit r1;
        bit tog;
        int exp_who;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int who, gap, len;
        bit dok, idle_ok;

        // requests, m_ready toggle, expected winner (last_grant starts at 1)
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 0};

        reset = 1'b0; s0_req = 0; s1_req = 0; fft_wayt_data = 0;
        fft_complete = 0; m_ready = 0; fft_out_i = '0; fft_out_q = '0;
        s0_data_i = '0; s0_data_q = '0; s1_data_i = '0; s1_data_q = '0;
        step(); step();
        chk("reset fft_valid", fft_valid, 0);
        chk("reset s0_ready", s0_ready, 0);
        chk("reset s1_ready", s1_ready, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_last", m_last, 0);
        chk("reset m_tag", m_tag, 0);
        chk("reset err_orphan", err_orphan, 0);
        reset = 1'b1;

        // Orphan completion with no frames outstanding.
        step();
        fft_complete = 1'b1; #1;
        chk("orphan m_valid", m_valid, 0);
        step();
        fft_complete = 1'b0;
        chk("orphan set", err_orphan, 1);
        step();
        chk("orphan sticky", err_orphan, 1);
        reset = 1'b0; #1;
        chk("orphan cleared by reset", err_orphan, 0);
        step();
        reset = 1'b1;

        // Table: one grant + burst + drained output frame per record.
        fft_wayt_data = 1'b1;
        foreach (tbl[i]) begin
            step();
            s0_req = tbl[i].r0;
            s1_req = tbl[i].r1;
            burst(1'b1, who, gap, len, dok);
            chk($sformatf("vec%0d winner", i), who, tbl[i].exp_who);
            chk($sformatf("vec%0d grant latency", i), gap, 1);
            chk($sformatf("vec%0d burst length", i), len, NFFT);
            chk($sformatf("vec%0d burst data/ready", i), dok, 1);
            drain(tbl[i].tog, tbl[i].exp_who[0], $sformatf("vec%0d", i));
        end

        // Continuous contention fills the tag FIFO: 0,1,0,1 then stall.
        reset_pulse();
        step();
        s0_req = 1'b1; s1_req = 1'b1;
        for (int b = 0; b < 4; b++) begin
            burst(1'b0, who, gap, len, dok);
            chk($sformatf("rr burst%0d winner", b), who, b % 2);
            chk($sformatf("rr burst%0d gap", b), (b == 0) ? (gap == 1) : (gap >= 1), 1);
            chk($sformatf("rr burst%0d length", b), len, NFFT);
            chk($sformatf("rr burst%0d data/ready", b), dok, 1);
        end
        idle_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (s0_ready || s1_ready || fft_valid) idle_ok = 1'b0;
            step(); #1;
        end
        chk("full fifo blocks grant", idle_ok, 1);
        drain(1'b0, 1'b0, "full drain0");
        #1;
        chk("no grant before pop takes effect", s0_ready | s1_ready, 0);
        step();
        chk("grant after pop", s0_ready, 1);
        s0_req = 1'b0; s1_req = 1'b0;
        drain(1'b0, 1'b1, "full drain1");
        drain(1'b1, 1'b0, "full drain2");
        drain(1'b0, 1'b1, "full drain3");
        drain(1'b0, 1'b0, "full drain4");
        fft_complete = 1'b1; #1;
        chk("fifo empty after drains", m_valid, 0);
        fft_complete = 1'b0;

        // Reset in the middle of a burst.
        reset_pulse();
        step();
        s0_req = 1'b1;
        step(); step();
        chk("midload burst running", s0_ready, 1);
        #2;
        reset = 1'b0; #1;
        chk("midload fft_valid drops", fft_valid, 0);
        chk("midload s0_ready drops", s0_ready, 0);
        chk("midload m_valid", m_valid, 0);
        chk("midload m_last", m_last, 0);
        fft_wayt_data = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("idle after release", fft_valid, 0);
        fft_wayt_data = 1'b1;
        step();
        chk("fresh grant after release", s0_ready, 1);
        s0_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Round-robin frame scheduler that shares one `myFFT` core between two sample requesters. Grants whole NFFT-sample frames and streams the winner's samples into the core with a contiguous `valid` burst. Tags each frame with its requester ID and returns the matching ID alongside the core's output burst. Sits between the OFDM symbol sources and the FFT instance, and drives that core's `valid`, `data_in_*` and `flag_ready_recive`.

## Interface
- `SIZE_BUFFER`, 8: log2 of NFFT; NFFT = 2**SIZE_BUFFER.
- `DATA_FFT_SIZE`, 16: input sample width per component.
- `DATA_OUT_SIZE`, 22: FFT output width per component (DATA_FFT_SIZE + SIZE_BUFFER - 2).
- `TAG_DEPTH_LOG`, 2: log2 of the in-flight frame tag FIFO depth (default 4).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s0_req`, `s1_req`  in  1  requester N holds a full frame ready.
- `s0_data_i/q`, `s1_data_i/q`  in  DATA_FFT_SIZE  requester samples.
- `s0_ready`, `s1_ready`  out  1  sample is consumed this cycle.
- `fft_valid`  out  1  connects to the core's `valid`.
- `fft_data_i/q`  out  DATA_FFT_SIZE  connect to the core's `data_in_*`.
- `fft_wayt_data`  in  1  core's `flag_wayt_data`; the core can accept a frame.
- `fft_complete`  in  1  core's `complete`; an output sample is present.
- `fft_out_i/q`  in  DATA_OUT_SIZE  core's `data_out_*`.
- `fft_ready_recive`  out  1  connects to the core's `flag_ready_recive`.
- `m_valid`, `m_last`  out  1  output sample valid; last sample of the frame.
- `m_tag`  out  1  requester ID of the current output frame.
- `m_data_i/q`  out  DATA_OUT_SIZE  output samples.
- `m_ready`  in  1  downstream accepts the sample.
- `err_orphan`  out  1  sticky flag: `fft_complete` was seen with the tag FIFO empty.

## Operation
- Input FSM has two states: IDLE and LOAD.
- IDLE → LOAD when all of these hold: `fft_wayt_data`=1, tag FIFO not full, and any `sN_req`=1.
  - Winner is chosen round-robin against `last_grant`; when only one request is present, that requester wins.
  - On the transition: `sel`←winner, `last_grant`←winner, `in_cnt`←0, and tag `sel` is pushed into the FIFO.
- In LOAD:
  - `fft_valid`=1 and `fft_data`=`s<sel>_data`, both combinational.
  - `s<sel>_ready`=1; the other requester's ready is 0.
  - `in_cnt` increments each cycle. At `in_cnt`=NFFT-1, next state is IDLE.
  - No backpressure inside a frame. The requester must present a new sample every cycle while its ready is high.
  - Changes on `sN_req` during LOAD are ignored.
- Output path:
  - `m_valid` = `fft_complete` & FIFO not empty.
  - `m_data` = `fft_out`, passed straight through.
  - `m_tag` = FIFO head.
  - `fft_ready_recive` = `m_ready`.
- `out_cnt` increments on each cycle where `m_valid` & `m_ready`.
  - `m_last` = `m_valid` & (`out_cnt`=NFFT-1).
  - On the `m_last` handshake: pop the FIFO and set `out_cnt`←0.
- If `fft_complete`=1 while the FIFO is empty, set `err_orphan`. It clears only on reset.
- A push and a pop in the same cycle are both honoured; FIFO occupancy is unchanged.

## Timing
- Reset values:
  - All outputs 0; state IDLE; counters 0; FIFO empty.
  - `last_grant`=1, so requester 0 wins the first simultaneous request.
- Grant latency: `sN_ready` rises 1 cycle after the IDLE cycle in which grant conditions hold.
- Burst length: exactly NFFT consecutive cycles of `fft_valid`.
- Frame gap: at least 1 IDLE cycle between bursts.
- Output path has 0-cycle combinational latency.
- Reset asserted mid-LOAD ends the burst immediately, and `fft_valid` drops asynchronously. The core must also be reset.
- Full FIFO (2**TAG_DEPTH_LOG frames in flight): no grant is issued; requests stay pending.

## Configuration
- `FFT_SCHED_FRAME_CNT_EN`:
  - Defined: adds outputs `stat_frames0` and `stat_frames1` (16-bit each). Each counts completed `m_last` handshakes per tag, wraps at 65535→0, and resets to 0.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Only `s0_req`=1, `fft_wayt_data`=1 from reset → `s0_ready` high for exactly 256 cycles starting 1 cycle after the grant cycle; `fft_valid` mirrors it; `s1_ready` stays 0.
- `s0_req`=`s1_req`=1 held continuously → bursts alternate 0,1,0,1; each burst is 256 cycles with a gap of at least 1 cycle.
- Core returns 256 `fft_complete` cycles with `m_ready`=1 → `m_tag` equals the granted ID, `m_last` is set only on the 256th sample, and the FIFO pops once.
- `m_ready` toggles 1/0 each cycle during output → `fft_ready_recive` tracks `m_ready`; `m_last` arrives after 256 accepted samples.
- 4 frames granted with no output drained → 5th request is not granted until the first `m_last` handshake.
- `fft_complete`=1 after reset with no grants → `err_orphan`=1 and `m_valid`=0; reset asserted mid-LOAD → all outputs 0 the same cycle, and state is IDLE after release.
